// File: rtl/store_buffer_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : store_pkg
// Brief    : Shared types and helpers for the store buffer unit: store-size
//            and FSM encodings, the queued entry layout, and the combinational
//            alignment / lane-steering functions.
// Revision : 1.0 - initial release
// ============================================================================
package store_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_XFER = 2'b10
  } state_e;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // A request is dropped when its address is not aligned to its size,
  // or when it uses the reserved size encoding.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = lo[0];
      SIZE_W:  bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Word-aligned address, data replicated onto every lane, and byte selects
  // marking the lanes actually written.
  function automatic entry_t build_entry(input logic [31:0] addr,
                                         input logic [31:0] data,
                                         input logic [1:0]  size);
    entry_t e;
    e.adr = {addr[31:2], 2'b00};
    case (size)
      SIZE_B: begin
        e.dat = {4{data[7:0]}};
        e.sel = 4'b0001 << addr[1:0];
      end
      SIZE_H: begin
        e.dat = {2{data[15:0]}};
        e.sel = 4'b0011 << {addr[1], 1'b0};
      end
      default: begin
        e.dat = data;
        e.sel = 4'b1111;
      end
    endcase
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_buffer_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_bus_t
// Brief    : Write-only Wishbone bus with arbitration grant, as seen by the
//            store buffer (master) and the fabric/slave side.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_bus_t;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_ms;
  logic [3:0]  wb_sel;
  logic        wb_lock;
  logic        wb_tgc;
  logic        wb_tga;
  logic        wb_tgd_ms;
  logic        wb_ack;
  logic        wb_err;
  logic        wb_gnt;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_ms, wb_sel,
           wb_lock, wb_tgc, wb_tga, wb_tgd_ms,
    input  wb_ack, wb_err, wb_gnt
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_ms, wb_sel,
           wb_lock, wb_tgc, wb_tga, wb_tgd_ms,
    output wb_ack, wb_err, wb_gnt
  );
endinterface
`default_nettype wire

// File: rtl/store_buffer_unit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO, power-of-two depth, show-ahead read port,
//            occupancy count. Push is ignored when full, pop when empty.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst_i,
  input  wire logic                     push_i,
  input  wire logic [WIDTH-1:0]         din_i,
  input  wire logic                     pop_i,
  output logic      [WIDTH-1:0]         dout_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic      [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible through the count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
endmodule
`default_nettype wire

// File: rtl/store_buffer_unit.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer_unit
// Brief    : Posted store queue. Checks alignment, steers data onto byte lanes,
//            queues entries FIFO and drains them onto a granted Wishbone bus
//            with back-to-back strobes, bus-error reporting and a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer_unit
  import store_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  wire logic                   clk,
  input  wire logic                   rst_i,
  input  wire logic                   req_valid_i,
  output logic                        req_ready_o,
  input  wire logic [31:0]            req_addr_i,
  input  wire logic [31:0]            req_data_i,
  input  wire logic [1:0]             req_size_i,
  output logic                        misalign_o,
  output logic                        err_o,
  output logic                        empty_o,
  output logic [$clog2(DEPTH):0]      count_o,
  wb_bus_t.master                     wb_bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e               state_q;
  state_e               state_d;
  logic [TW-1:0]        tmo_q;
  logic                 err_q;
  logic                 misalign_q;

  logic                 accept;
  logic                 bad_req;
  logic                 do_push;
  logic                 do_pop;
  logic                 bus_err;
  entry_t               push_entry;
  entry_t               head;
  logic [ENTRY_W-1:0]   fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;

  // Request acceptance, alignment check and lane steering ahead of the queue.
  always_comb begin
    accept     = req_valid_i && req_ready_o;
    bad_req    = is_misaligned(req_size_i, req_addr_i[1:0]);
    do_push    = accept && !bad_req;
    push_entry = build_entry(req_addr_i, req_data_i, req_size_i);
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_i   (rst_i),
    .push_i  (do_push),
    .din_i   (push_entry),
    .pop_i   (do_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head = entry_t'(fifo_dout);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state plus head pop / error decisions; err beats ack, both beat
  // grant loss, and timeout only fires while still granted.
  always_comb begin
    state_d = state_q;
    do_pop  = 1'b0;
    bus_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (wb_bus.wb_gnt) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (wb_bus.wb_err || wb_bus.wb_ack) begin
          do_pop  = 1'b1;
          bus_err = wb_bus.wb_err;
          state_d = (fifo_count > CW'(1)) ? ST_XFER : ST_IDLE;
        end else if (!wb_bus.wb_gnt) begin
          state_d = ST_REQ;
        end else if (tmo_q == TMO_LAST) begin
          do_pop  = 1'b1;
          bus_err = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs decoded from state; address/data/select only drive in XFER.
  always_comb begin
    wb_bus.wb_cyc    = (state_q != ST_IDLE);
    wb_bus.wb_stb    = (state_q == ST_XFER);
    wb_bus.wb_adr    = '0;
    wb_bus.wb_dat_ms = '0;
    wb_bus.wb_sel    = '0;
    if (state_q == ST_XFER) begin
      wb_bus.wb_adr    = head.adr;
      wb_bus.wb_dat_ms = head.dat;
      wb_bus.wb_sel    = head.sel;
    end
  end

  assign wb_bus.wb_we     = 1'b1;
  assign wb_bus.wb_lock   = 1'b0;
  assign wb_bus.wb_tgc    = 1'b0;
  assign wb_bus.wb_tga    = 1'b0;
  assign wb_bus.wb_tgd_ms = 1'b0;

  // Cycles spent strobing the current head; restarts on every pop or stall.
  always_ff @(posedge clk) begin
    if (rst_i || state_q != ST_XFER || do_pop || !wb_bus.wb_gnt) tmo_q <= '0;
    else                                                         tmo_q <= tmo_q + TW'(1);
  end

  // One-cycle status pulses, registered so they follow the causing edge.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      err_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      err_q      <= bus_err;
      misalign_q <= accept && bad_req;
    end
  end

  assign req_ready_o = !fifo_full;
  assign misalign_o  = misalign_q;
  assign err_o       = err_q;
  assign count_o     = fifo_count;
  assign empty_o     = fifo_empty && (state_q == ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_store_buffer_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer_unit
// Brief    : Self-checking bench: vector table of single stores plus directed
//            sequences for queue-full drain, timeout, bus error and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer_unit;
  import store_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int CW      = $clog2(DEPTH) + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic        mis;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [31:0]   req_addr_i;
  logic [31:0]   req_data_i;
  logic [1:0]    req_size_i;
  logic          misalign_o;
  logic          err_o;
  logic          empty_o;
  logic [CW-1:0] count_o;

  wb_bus_t wb();

  store_buffer_unit #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .req_size_i  (req_size_i),
    .misalign_o  (misalign_o),
    .err_o       (err_o),
    .empty_o     (empty_o),
    .count_o     (count_o),
    .wb_bus      (wb)
  );

  always #5 clk = ~clk;

  int     n_vec = 0;
  int     n_bad = 0;
  entry_t sb[$];
  logic   ack_en;
  logic   err_en;
  int     err_target;
  int     done_cnt = 0;
  int     err_seen = 0;
  int     mis_seen = 0;
  int     cyc_seen = 0;
  int     stb_seen = 0;
  vec_t   vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // One clock: at the falling edge the slave responds and the bench observes.
  task automatic tick();
    entry_t e;
    @(negedge clk);
    wb.wb_ack = ack_en && wb.wb_stb;
    wb.wb_err = err_en && wb.wb_stb && (done_cnt == err_target);
    if (err_o)      err_seen++;
    if (misalign_o) mis_seen++;
    if (wb.wb_cyc)  cyc_seen++;
    if (wb.wb_stb)  stb_seen++;
    if (wb.wb_stb && (wb.wb_ack || wb.wb_err)) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_unexpected: strobe to 0x%0h, none expected", wb.wb_adr);
      end else begin
        e = sb.pop_front();
        chk("wb_adr", wb.wb_adr, e.adr);
        chk("wb_dat", wb.wb_dat_ms, e.dat);
        chk("wb_sel", wb.wb_sel, e.sel);
        chk("wb_we", wb.wb_we, 1);
      end
      done_cnt++;
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                      input logic mis, input entry_t exp);
    int guard;
    guard = 0;
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_data_i  = d;
    req_size_i  = s;
    while (!req_ready_o && guard < 100) begin
      tick();
      guard++;
    end
    if (!req_ready_o) fail_now("send_ready");
    if (!mis) sb.push_back(exp);
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic drain(output int cyc_low);
    cyc_low = 0;
    for (int g = 0; g < 100 && !empty_o; g++) begin
      tick();
      if (!empty_o && !wb.wb_cyc) cyc_low++;
    end
    if (!empty_o) fail_now("drain_empty");
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                              input logic m, input logic [31:0] ea, input logic [31:0] ed,
                              input logic [3:0] es);
    vec_t v;
    v.addr = a; v.data = d; v.size = s; v.mis = m; v.adr = ea; v.dat = ed; v.sel = es;
    return v;
  endfunction

  initial begin
    int d0, m0, c0, s0, e0, cl, guard;
    vecs[0]  = mk(32'h0000_1003, 32'h0000_00AB, 2'b00, 1'b0, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000);
    vecs[1]  = mk(32'h0000_1000, 32'h1234_5678, 2'b00, 1'b0, 32'h0000_1000, 32'h7878_7878, 4'b0001);
    vecs[2]  = mk(32'h0000_2002, 32'h0000_BEEF, 2'b01, 1'b0, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100);
    vecs[3]  = mk(32'h0000_2000, 32'hCAFE_F00D, 2'b01, 1'b0, 32'h0000_2000, 32'hF00D_F00D, 4'b0011);
    vecs[4]  = mk(32'h0000_3004, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0000_3004, 32'hDEAD_BEEF, 4'b1111);
    vecs[5]  = mk(32'h0000_2001, 32'h0000_1111, 2'b01, 1'b1, 32'h0, 32'h0, 4'h0);
    vecs[6]  = mk(32'h0000_3006, 32'h2222_2222, 2'b10, 1'b1, 32'h0, 32'h0, 4'h0);
    vecs[7]  = mk(32'h0000_4000, 32'h3333_3333, 2'b11, 1'b1, 32'h0, 32'h0, 4'h0);
    vecs[8]  = mk(32'h0000_5001, 32'h0000_005A, 2'b00, 1'b0, 32'h0000_5000, 32'h5A5A_5A5A, 4'b0010);
    vecs[9]  = mk(32'hFFFF_FFFE, 32'h0000_1234, 2'b01, 1'b0, 32'hFFFF_FFFC, 32'h1234_1234, 4'b1100);
    vecs[10] = mk(32'h0000_7003, 32'h4444_4444, 2'b10, 1'b1, 32'h0, 32'h0, 4'h0);
    vecs[11] = mk(32'h0000_7002, 32'hFFFF_FF01, 2'b00, 1'b0, 32'h0000_7000, 32'h0101_0101, 4'b0100);

    rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_data_i = '0; req_size_i = '0;
    wb.wb_gnt = 1'b0; wb.wb_ack = 1'b0; wb.wb_err = 1'b0;
    ack_en = 1'b0; err_en = 1'b0; err_target = -1;
    tick(); tick(); tick();

    // Reset state
    chk("rst_cyc", wb.wb_cyc, 0);
    chk("rst_stb", wb.wb_stb, 0);
    chk("rst_sel", wb.wb_sel, 0);
    chk("rst_err", err_o, 0);
    chk("rst_misalign", misalign_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_ready", req_ready_o, 1);
    chk("tie_offs", {wb.wb_lock, wb.wb_tgc, wb.wb_tga, wb.wb_tgd_ms}, 0);
    rst_i = 1'b0;
    tick();

    // Latency into an empty queue with grant already high: IDLE, REQ, XFER
    wb.wb_gnt = 1'b1; ack_en = 1'b1;
    d0 = done_cnt;
    send(32'h0000_1003, 32'h0000_00AB, 2'b00, 1'b0, '{32'h0000_1000, 32'hABAB_ABAB, 4'b1000});
    chk("lat_idle_cyc", wb.wb_cyc, 0);
    chk("lat_count", count_o, 1);
    chk("lat_empty", empty_o, 0);
    tick();
    chk("lat_req_cyc", wb.wb_cyc, 1);
    chk("lat_req_stb", wb.wb_stb, 0);
    tick();
    chk("lat_xfer_stb", wb.wb_stb, 1);
    drain(cl);
    chk("lat_done", done_cnt - d0, 1);
    chk("lat_count_end", count_o, 0);

    // Table of single stores
    for (int i = 0; i < 12; i++) begin
      d0 = done_cnt; m0 = mis_seen; c0 = cyc_seen;
      send(vecs[i].addr, vecs[i].data, vecs[i].size, vecs[i].mis,
           '{vecs[i].adr, vecs[i].dat, vecs[i].sel});
      drain(cl);
      tick(); tick();
      chk($sformatf("vec%0d_misalign", i), mis_seen - m0, vecs[i].mis ? 1 : 0);
      chk($sformatf("vec%0d_xfers", i), done_cnt - d0, vecs[i].mis ? 0 : 1);
      if (vecs[i].mis) chk($sformatf("vec%0d_no_bus", i), cyc_seen - c0, 0);
    end

    // Fill the queue without grant, then drain back-to-back
    wb.wb_gnt = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      chk($sformatf("fill%0d_count", k), count_o, k);
      send(32'h0000_0100 + 32'(4 * k), 32'h1111_0000 + 32'(k), 2'b10, 1'b0,
           '{32'h0000_0100 + 32'(4 * k), 32'h1111_0000 + 32'(k), 4'b1111});
    end
    chk("full_count", count_o, DEPTH);
    chk("full_ready", req_ready_o, 0);
    chk("full_req_cyc", wb.wb_cyc, 1);
    chk("full_req_stb", wb.wb_stb, 0);
    wb.wb_gnt = 1'b1;
    s0 = stb_seen; d0 = done_cnt;
    drain(cl);
    chk("b2b_strobes", stb_seen - s0, DEPTH);
    chk("b2b_cyc_drops", cl, 0);
    chk("b2b_done", done_cnt - d0, DEPTH);

    // Slave never answers: timeout aborts head, next entry proceeds
    ack_en = 1'b0;
    s0 = stb_seen; e0 = err_seen; d0 = done_cnt;
    send(32'h0000_0600, 32'hAAAA_0001, 2'b10, 1'b0, '{32'h0000_0600, 32'hAAAA_0001, 4'b1111});
    send(32'h0000_0604, 32'hAAAA_0002, 2'b10, 1'b0, '{32'h0000_0604, 32'hAAAA_0002, 4'b1111});
    guard = 0;
    while (err_seen == e0 && guard < 100) begin
      tick();
      guard++;
    end
    if (err_seen == e0) fail_now("timeout_err");
    chk("timeout_stb_cycles", stb_seen - s0, TIMEOUT);
    chk("timeout_cyc_drop", wb.wb_cyc, 0);
    chk("timeout_count", count_o, 1);
    void'(sb.pop_front());
    ack_en = 1'b1;
    drain(cl);
    tick(); tick();
    chk("timeout_err_pulses", err_seen - e0, 1);
    chk("timeout_done", done_cnt - d0, 1);

    // Bus error (with ack also high) on the 2nd of 3 stores
    wb.wb_gnt = 1'b0;
    err_en = 1'b1; err_target = done_cnt + 1;
    e0 = err_seen; d0 = done_cnt;
    for (int k = 0; k < 3; k++)
      send(32'h0000_0800 + 32'(4 * k), 32'h5555_0000 + 32'(k), 2'b10, 1'b0,
           '{32'h0000_0800 + 32'(4 * k), 32'h5555_0000 + 32'(k), 4'b1111});
    wb.wb_gnt = 1'b1;
    drain(cl);
    tick(); tick();
    chk("buserr_pulses", err_seen - e0, 1);
    chk("buserr_done", done_cnt - d0, 3);
    chk("buserr_count", count_o, 0);
    chk("buserr_cyc_drops", cl, 0);
    err_en = 1'b0; err_target = -1;

    // Reset during a transfer with 3 entries queued
    wb.wb_gnt = 1'b0; ack_en = 1'b0;
    for (int k = 0; k < 3; k++)
      send(32'h0000_0900 + 32'(4 * k), 32'h6666_0000 + 32'(k), 2'b10, 1'b0,
           '{32'h0000_0900 + 32'(4 * k), 32'h6666_0000 + 32'(k), 4'b1111});
    wb.wb_gnt = 1'b1;
    guard = 0;
    while (!wb.wb_stb && guard < 20) begin
      tick();
      guard++;
    end
    chk("midrst_stb_before", wb.wb_stb, 1);
    rst_i = 1'b1;
    tick();
    chk("midrst_cyc", wb.wb_cyc, 0);
    chk("midrst_count", count_o, 0);
    chk("midrst_empty", empty_o, 1);
    chk("midrst_sel", wb.wb_sel, 0);
    sb.delete();
    rst_i = 1'b0;
    ack_en = 1'b1;
    d0 = done_cnt;
    for (int k = 0; k < 5; k++) tick();
    chk("midrst_no_xfer", done_cnt - d0, 0);
    chk("midrst_still_empty", empty_o, 1);
    chk("sb_leftover", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/store_buffer_unit.md
STORE_BUFFER_UNIT -- requirements
Module: store_buffer_unit

Interface
REQ-001 Parameter DEPTH, default 4: store-queue entries, power of two, >= 2.
REQ-002 Parameter TIMEOUT, default 255: max cycles waiting for ack/err after stb before abort.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 req_valid_i  input  1  store request valid.
REQ-006 req_ready_o  output  1  queue can accept request.
REQ-007 req_addr_i  input  32  byte address.
REQ-008 req_data_i  input  32  store data, LSB-aligned.
REQ-009 req_size_i  input  2  store size: 00 byte, 01 half, 10 word; 11 reserved.
REQ-010 misalign_o  output  1  one-cycle pulse: request dropped (misaligned or reserved size).
REQ-011 err_o  output  1  one-cycle pulse: bus error or timeout on head entry.
REQ-012 empty_o  output  1  queue empty and no bus transfer active.
REQ-013 count_o  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 wb_bus  wb_bus_t.master  -  Wishbone master port; wb_we=1, wb_lock/tgc/tga/tgd_ms=0 constant.

Function
REQ-015 Handshake: request accepted when req_valid_i && req_ready_o at rising edge; req_ready_o = !full, no dependence on bus state in same cycle.
REQ-016 Acceptance check: half with addr[0]=1, word with addr[1:0]!=0, or size 11 -> accepted but not enqueued, misalign_o pulses next cycle.
REQ-017 Enqueued entry: {addr[31:2],2'b00}, lane-replicated data (byte x4, half x2, word as-is), sel: byte 4'b0001<<addr[1:0], half 4'b0011<<{addr[1],1'b0}, word 4'b1111.
REQ-018 FSM states IDLE, REQ, XFER.
REQ-019 IDLE: wb_cyc=0, wb_stb=0; if queue non-empty -> REQ next cycle.
REQ-020 REQ: wb_cyc=1, wb_stb=0; when wb_gnt=1 -> XFER next cycle.
REQ-021 XFER: wb_cyc=1, wb_stb=1, wb_adr/wb_dat_ms/wb_sel from head entry; held stable until ack/err/timeout.
REQ-022 XFER on wb_ack: pop head; if queue holds another entry stay in XFER (back-to-back, cyc held), else -> IDLE.
REQ-023 XFER on wb_err (err wins if ack and err both high): pop head, err_o pulses next cycle, same next-state rule as REQ-022.
REQ-024 XFER timeout counter resets on XFER entry and each pop; reaching TIMEOUT cycles: pop head, err_o pulse, -> IDLE (cyc dropped one cycle).
REQ-025 wb_gnt deasserting in XFER: stb/cyc dropped, -> REQ; head not popped, counter cleared.
REQ-026 Simultaneous push and pop: both occur, count_o unchanged; push while full never occurs (ready low).
REQ-027 Ordering strictly FIFO; queue pointers wrap modulo DEPTH.
REQ-028 Latency: request into empty queue, gnt already high -> stb asserted 3rd cycle after acceptance edge (IDLE, REQ, XFER).
REQ-029 empty_o = (count_o==0) && state==IDLE.

Reset
REQ-030 rst_i high at a rising edge: state IDLE, queue empty, counter 0; next cycle wb_cyc=wb_stb=0, wb_sel=0, err_o=misalign_o=0, count_o=0, empty_o=1, req_ready_o=1.
REQ-031 rst_i mid-transfer discards all entries including head; no ack after reset is counted.

Structure
REQ-032 Shared package store_pkg: size enum (SIZE_B, SIZE_H, SIZE_W), state enum, entry struct {adr, dat, sel}.
REQ-033 Queue implemented as sub-module sync_fifo (parametrised width/depth, full/empty/count).
REQ-034 Alignment/lane logic combinational in store_buffer_unit before sync_fifo push.

Verification
REQ-035 Byte store addr 0x1003 data 0xAB -> one XFER, adr 0x1000, sel 4'b1000, dat 0xABABABAB, queue empty after ack.
REQ-036 Push DEPTH words while gnt=0 -> req_ready_o=0 at count_o=DEPTH; raise gnt, ack every cycle -> DEPTH back-to-back strobes in order, cyc never drops.
REQ-037 Half store addr 0x2001 -> not enqueued, misalign_o single pulse, no bus activity.
REQ-038 Slave never acks, TIMEOUT=8 -> stb high 8 cycles, err_o pulse, entry popped, next entry proceeds.
REQ-039 wb_err on 2nd of 3 stores -> err_o one pulse, 3rd store still issued, count_o 0 at end.
REQ-040 Assert rst_i during XFER with 3 entries queued -> next cycle cyc=0, count_o=0, empty_o=1.
